// File: rtl/msb_scan_stream.sv
// msb_scan_stream: chunked MSB/LSB set-bit position finder with
// valid/ready input and output handshakes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data [WIDTH]     word to scan
//   in_mode             0 = highest set bit, 1 = lowest set bit
//   out_valid/out_ready output handshake
//   out_pos [POS_W]     absolute bit index of the found bit
//   out_zero            word was all zeros
//   busy                block is scanning or holding a result
module msb_scan_stream #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8,
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               mode_q, mode_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               zero_q, zero_d;

    // Word viewed as an array of chunks; chunk 0 holds the LSBs.
    logic [NCH-1:0][CHUNK-1:0] chunks;
    logic [KW-1:0]             msb_idx;
    logic [CHUNK-1:0]          chunk;
    logic                      chunk_nz;
    logic                      last_chunk;
    logic [CW-1:0]             hi_idx;
    logic [CW-1:0]             lo_idx;
    logic [31:0]               base_lsb;
    logic [31:0]               base_msb;
    logic [31:0]               abs_pos;

    assign chunks = word_q;

    // MSB mode walks chunks from the top, LSB mode from the bottom.
    always_comb begin
        msb_idx    = KW'(NCH - 1) - k_q;
        chunk      = mode_q ? chunks[k_q] : chunks[msb_idx];
        chunk_nz   = |chunk;
        last_chunk = (k_q == KW'(NCH - 1));
    end

    // Highest set bit inside the current chunk.
    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i]) hi_idx = CW'(i);
        end
    end

    // Lowest set bit inside the current chunk.
    always_comb begin
        lo_idx = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) lo_idx = CW'(i);
        end
    end

    // Chunk-relative index plus the chunk's bit offset in the word.
    always_comb begin
        base_lsb = 32'(k_q) * 32'(CHUNK);
        base_msb = 32'(WIDTH - CHUNK) - base_lsb;
        if (mode_q) abs_pos = base_lsb + 32'(lo_idx);
        else        abs_pos = base_msb + 32'(hi_idx);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            word_q  <= '0;
            mode_q  <= 1'b0;
            pos_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        zero_d  = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    word_d  = in_data;
                    mode_d  = in_mode;
                    k_d     = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (chunk_nz) begin
                    pos_d   = POS_W'(abs_pos);
                    zero_d  = 1'b0;
                    state_d = S_DONE;
                end else if (last_chunk) begin
                    pos_d   = '0;
                    zero_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; in_ready is gated by rst_n so no word is taken in reset.
    always_comb begin
        in_ready  = (state_q == S_IDLE) && rst_n;
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        out_pos   = pos_q;
        out_zero  = zero_q;
    end

endmodule

// File: tb/tb_msb_scan_stream.sv
// tb_msb_scan_stream: scoreboard bench for msb_scan_stream
// (WIDTH=64, CHUNK=8, POS_W=8).
module tb_msb_scan_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pos;
    logic        out_zero;
    logic        busy;

    msb_scan_stream #(.WIDTH(64), .CHUNK(8), .POS_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] pos;
        logic       zero;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] w, input logic m);
        exp_t e;
        e.pos  = '0;
        e.zero = 1'b1;
        e.lat  = 8;
        e.acc  = 0;
        if (m) begin
            for (int i = 63; i >= 0; i--)
                if (w[i]) begin e.pos = 8'(i); e.zero = 1'b0; end
        end else begin
            for (int i = 0; i < 64; i++)
                if (w[i]) begin e.pos = 8'(i); e.zero = 1'b0; end
        end
        if (!e.zero)
            e.lat = m ? (int'(e.pos) / 8 + 1) : ((63 - int'(e.pos)) / 8 + 1);
        return e;
    endfunction

    // Output monitor: latency, hold stability and result compare.
    logic       ov_prev = 1'b0;
    logic [8:0] held;
    int         lat_seen;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                chk("result_expected", 64'(q.size() > 0), 64'd1);
                lat_seen = -1;
                if (q.size() > 0) lat_seen = cyc - q[0].acc;
                held = {out_zero, out_pos};
            end else if (out_valid) begin
                chk("hold_stable", 64'({out_zero, out_pos}), 64'(held));
            end
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_pos", 64'(out_pos), 64'(e.pos));
                chk("out_zero", 64'(out_zero), 64'(e.zero));
                chk("latency", 64'(lat_seen), 64'(e.lat));
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input logic [63:0] w, input logic m,
                        input bit push);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = w;
        in_mode  = m;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else if (push) begin
            e     = model(w, m);
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
        @(negedge clk);
    endtask

    task automatic run(input logic [63:0] w, input logic m);
        send(w, m, 1'b1);
        drain();
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pos", 64'(out_pos), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        run(64'h0000000000003131, 1'b0);
        run(64'h0000000000003131, 1'b1);
        run(64'h3100000000003131, 1'b0);
        run(64'h3100000000003131, 1'b1);
        run(64'h0000000000000001, 1'b0);
        run(64'h0, 1'b0);
        run(64'h0, 1'b1);

        // Backpressure with a stray in_valid while DONE.
        out_ready = 1'b0;
        send(64'h8000000000000000, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 1 || i == 2);
            in_data  = 64'h5;
            in_mode  = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_out_pos", 64'(out_pos), 64'd63);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_last", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);
        chk("bp_valid_dropped", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("bp_stray_ignored", 64'(busy), 64'd0);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset while chunk 3 is being scanned.
        send(64'h1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_out_pos", 64'(out_pos), 64'd0);
        chk("mr_out_zero", 64'(out_zero), 64'd0);
        chk("mr_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        run(64'h10, 1'b0);

        // Inputs changing after the accept edge are ignored.
        send(64'h00F0000000000000, 1'b0, 1'b1);
        in_data = '0;
        in_mode = 1'b1;
        drain();

        for (int i = 0; i < 8; i++)
            run({$urandom, $urandom} >> $urandom_range(0, 63),
                1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msb_scan_stream.md
Name: msb_scan_stream

Overview:
Parametrised successor to the single-cycle N-bit MSB position finder. It accepts one WIDTH-bit word per transaction over a valid/ready handshake. The word is scanned CHUNK bits per cycle, from the top (MSB mode) or from the bottom (LSB mode), and the scan stops at the first chunk that contains a set bit. The block returns the absolute bit position plus a zero flag over a second valid/ready handshake, and sits between a producer and consumer pipeline stage in the bit-manipulation datapath.

Parameters:
WIDTH, 64, input word width; must be a multiple of CHUNK.
CHUNK, 8, bits examined per SCAN cycle; must be a power of two, at most WIDTH.
POS_W, 8, output position width; must be at least clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to scan
in_mode  input  1  0 = find highest set bit (MSB), 1 = find lowest set bit (LSB)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_pos  output  POS_W  absolute bit index of the found bit (bit 0 = LSB of in_data)
out_zero  output  1  1 when in_data was all zeros
busy  output  1  high in SCAN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n, sampled at the rising edge.
- Reset values: state = IDLE; out_valid = 0; out_pos = 0; out_zero = 0; busy = 0; chunk index = 0; latched word and mode cleared.
- in_ready = 1 only in IDLE with rst_n high. It is combinational from state.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - An edge with in_valid & in_ready latches in_data and in_mode, sets chunk index k = 0 and moves to SCAN.
  - Without that handshake, the block stays in IDLE.
- SCAN, one cycle per chunk:
  - MSB mode, chunk k = bits [WIDTH-1-k*CHUNK : WIDTH-k*CHUNK-CHUNK].
  - LSB mode, chunk k = bits [k*CHUNK+CHUNK-1 : k*CHUNK].
  - If chunk k is non-zero: out_pos <= absolute index of its highest set bit (MSB mode) or lowest set bit (LSB mode); out_zero <= 0; go to DONE.
  - Else if k = WIDTH/CHUNK-1: out_pos <= 0; out_zero <= 1; go to DONE.
  - Else: k <= k+1.
- DONE:
  - out_valid = 1. out_pos and out_zero are held stable while out_ready = 0.
  - An edge with out_valid & out_ready goes to IDLE and drops out_valid.
  - A new word is not accepted in the same edge; in_ready rises in the following cycle.
- Latency: out_valid rises k+1 edges after the accepting edge, where k is the index of the first non-zero chunk in scan order. For an all-zero word, latency is WIDTH/CHUNK edges.
- Throughput: at most one transaction per latency+2 cycles. No overlap between transactions.
- Sampling rules:
  - in_data and in_mode are sampled only at the accept edge; later changes are ignored.
  - in_valid is ignored outside IDLE.
- out_pos is zero-extended to POS_W bits.
- Reset mid-operation: rst_n low at any edge forces IDLE and the reset values regardless of state or handshakes. Any partially scanned word is discarded and no result is emitted.
- Simultaneous rst_n low and in_valid: reset wins and the word is not accepted.
- The WIDTH = CHUNK configuration degenerates to a fixed 1-cycle latency.

Test Plan (WIDTH=64, CHUNK=8, POS_W=8, out_ready=1 unless stated):
1. Word 64'h0000000000003131, mode 0 -> out_pos=13, out_zero=0, out_valid 7 edges after accept. Same word, mode 1 -> out_pos=0, latency 1.
2. Word 64'h3100000000003131, mode 0 -> out_pos=61, latency 1. Mode 1 -> out_pos=0, latency 1.
3. Word 64'h0000000000000001, mode 0 -> out_pos=0, out_zero=0, latency 8. Word 64'h0 in either mode -> out_pos=0, out_zero=1, latency 8.
4. Backpressure: word 64'h8000000000000000, mode 1, out_ready held 0 for 4 cycles -> out_pos=63 held stable, in_ready=0 throughout. A new in_valid pulse during DONE is not accepted. Result is consumed on the first out_ready=1 edge, and in_ready=1 the next cycle.
5. Reset mid-scan: word 64'h1, mode 0, rst_n=0 for one edge at scan chunk 3 -> out_valid never rises for that word, all outputs at reset values, in_ready=1 after release. Next word 64'h10 -> out_pos=4, latency 8.
6. Input change after accept: accept 64'h00F0000000000000 mode 0, then drive in_data=0 and in_mode=1 -> out_pos=55, latency 2.
